// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - control/status bundle between a consumer and countdown_timer
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             pause;
    logic             stop;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output load, load_val, pause, stop, ack,
        input  count, busy, done, tc
    );

    modport slave (
        input  load, load_val, pause, stop, ack,
        output count, busy, done, tc
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse and done/ack handshake
// Optional periodic mode: define COUNTDOWN_AUTO_RELOAD_EN.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   tmr
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == S_RUN);
            done_q   <= (state_d == S_DONE);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        // load wins in every state; in DONE it doubles as the acknowledge
        if (tmr.load) begin
            if (tmr.load_val != '0) begin
                count_d  = tmr.load_val;
                state_d  = S_RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                reload_d = tmr.load_val;
`endif
            end else begin
                count_d = '0;
                tc_d    = 1'b1;
                state_d = S_DONE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_RUN: begin
                    if (tmr.stop) begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end else if (tmr.pause) begin
                        count_d = count_q;
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        tc_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        count_d = reload_q;
`else
                        count_d = '0;
                        state_d = S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    if (tmr.ack || tmr.stop) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign tmr.count = count_q;
    assign tmr.busy  = busy_q;
    assign tmr.done  = done_q;
    assign tmr.tc    = tc_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - vector-table and scoreboard bench for countdown_timer
module tb_countdown_timer;
    localparam int W = 4;

    typedef struct {
        logic         ld;
        logic [W-1:0] val;
        logic         pause;
        logic         stop;
        logic         ack;
        logic [W-1:0] cnt;
        logic         busy;
        logic         done;
        logic         tc;
    } vec_t;

    logic clk;
    logic rst;
    countdown_timer_if #(.WIDTH(W)) tif ();

    countdown_timer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .tmr (tif)
    );

    vec_t           vecs[$];
    logic [W+2:0]   exp_q[$];
    int             n_vec = 0;
    int             n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic ld, input logic [W-1:0] val, input logic p,
                                input logic s, input logic a, input logic [W-1:0] c,
                                input logic b, input logic d, input logic t);
        vec_t v;
        v.ld = ld; v.val = val; v.pause = p; v.stop = s; v.ack = a;
        v.cnt = c; v.busy = b; v.done = d; v.tc = t;
        return v;
    endfunction

    task automatic add(input logic ld, input logic [W-1:0] val, input logic p, input logic s,
                       input logic a, input logic [W-1:0] c, input logic b, input logic d,
                       input logic t);
        vecs.push_back(mk(ld, val, p, s, a, c, b, d, t));
    endtask

    task automatic nop(input logic [W-1:0] c, input logic b, input logic d, input logic t);
        add(1'b0, '0, 1'b0, 1'b0, 1'b0, c, b, d, t);
    endtask

    task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d busy=%b done=%b tc=%b, expected cnt=%0d busy=%b done=%b tc=%b",
                     name, act[W+2:3], act[2], act[1], act[0],
                     expv[W+2:3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        logic [W+2:0] expv;
        tif.load     = v.ld;
        tif.load_val = v.val;
        tif.pause    = v.pause;
        tif.stop     = v.stop;
        tif.ack      = v.ack;
        exp_q.push_back({v.cnt, v.busy, v.done, v.tc});
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        check(name, {tif.count, tif.busy, tif.done, tif.tc}, expv);
    endtask

    initial begin
        rst          = 1'b1;
        tif.load     = 1'b0;
        tif.load_val = '0;
        tif.pause    = 1'b0;
        tif.stop     = 1'b0;
        tif.ack      = 1'b0;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        add(1, 4, 0, 0, 0, 4, 1, 0, 0);
        for (int p = 0; p < 3; p++) begin
            nop(3, 1, 0, 0); nop(2, 1, 0, 0); nop(1, 1, 0, 0); nop(4, 1, 0, 1);
        end
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
`else
        nop(0, 0, 0, 0);
        // load 3, count down, done holds until ack
        add(1, 3, 0, 0, 0, 3, 1, 0, 0);
        nop(2, 1, 0, 0); nop(1, 1, 0, 0); nop(0, 0, 1, 1); nop(0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // load 5 with two paused cycles at 4
        add(1, 5, 0, 0, 0, 5, 1, 0, 0);
        nop(4, 1, 0, 0);
        add(0, 0, 1, 0, 0, 4, 1, 0, 0);
        add(0, 0, 1, 0, 0, 4, 1, 0, 0);
        nop(3, 1, 0, 0); nop(2, 1, 0, 0); nop(1, 1, 0, 0); nop(0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // stop mid-run (with pause also high: stop wins)
        add(1, 6, 0, 0, 0, 6, 1, 0, 0);
        nop(5, 1, 0, 0); nop(4, 1, 0, 0); nop(3, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // reload 9 while at 2
        add(1, 9, 0, 0, 0, 9, 1, 0, 0);
        for (int c = 8; c >= 2; c--) nop(W'(c), 1, 0, 0);
        add(1, 9, 0, 0, 0, 9, 1, 0, 0);
        nop(8, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // load on the terminal edge suppresses tc; load beats stop
        add(1, 2, 0, 0, 0, 2, 1, 0, 0);
        nop(1, 1, 0, 0);
        add(1, 3, 0, 0, 0, 3, 1, 0, 0);
        add(1, 2, 0, 1, 0, 2, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // load 0 goes straight to DONE; pause no effect; load 4 from DONE
        add(1, 0, 0, 0, 0, 0, 0, 1, 1);
        nop(0, 0, 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0, 0, 4, 1, 0, 0);
        nop(3, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // ack ignored in RUN and IDLE; stop in DONE returns to IDLE
        add(1, 2, 0, 0, 0, 2, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0);
        nop(0, 0, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // maximum count 15
        add(1, 15, 0, 0, 0, 15, 1, 0, 0);
        for (int c = 14; c >= 1; c--) nop(W'(c), 1, 0, 0);
        nop(0, 0, 1, 1);
        // load together with ack in DONE restarts
        add(1, 1, 0, 0, 1, 1, 1, 0, 0);
        nop(0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {tif.count, tif.busy, tif.done, tif.tc}, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset mid-run at count 2
        step(mk(1, 4, 0, 0, 0, 4, 1, 0, 0), "arst_load");
        step(mk(0, 0, 0, 0, 0, 3, 1, 0, 0), "arst_cnt3");
        step(mk(0, 0, 0, 0, 0, 2, 1, 0, 0), "arst_cnt2");
        #2;
        rst = 1'b1;
        #1;
        check("arst_immediate", {tif.count, tif.busy, tif.done, tif.tc}, '0);
        tif.load     = 1'b1;
        tif.load_val = 4'd5;
        tif.ack      = 1'b1;
        @(posedge clk);
        #1;
        check("arst_load_ack_ignored", {tif.count, tif.busy, tif.done, tif.tc}, '0);
        rst = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "arst_release_idle");
        step(mk(1, 2, 0, 0, 0, 2, 1, 0, 0), "arst_after_load");
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "arst_after_stop");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with a terminal-count pulse and a done/acknowledge handshake. It is the counting-down counterpart to the team's 4-bit up-counter. It serves as the delay and timeout primitive for control logic in the same design: a consumer loads a cycle count, waits for `done`, and acknowledges it. Optional auto-reload turns it into a periodic tick generator.

## Interface
Parameters:
- `WIDTH`, default 4: width of the count and the load value.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `load`: input, 1 bit. Start or restart request; samples `load_val`.
- `load_val`: input, `WIDTH` bits. Number of cycles to count.
- `pause`: input, 1 bit. Holds the count while in RUN.
- `stop`: input, 1 bit. Aborts RUN and returns to IDLE.
- `ack`: input, 1 bit. Acknowledges `done`.
- `count`: output, `WIDTH` bits. Current count value (registered).
- `busy`: output, 1 bit. High while in RUN.
- `done`: output, 1 bit. High while in DONE.
- `tc`: output, 1 bit. Terminal-count pulse, one cycle wide.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, `count`=0, `busy`=0, `done`=0, `tc`=0, reload register=0.
- Input priority in every state: `load` > `stop` > `pause`. `ack` is evaluated only in DONE.
- IDLE:
  - `load` with `load_val`≠0: `count`←`load_val`, reload register←`load_val`, go to RUN.
  - `load` with `load_val`=0: `count`←0, `tc`←1, go to DONE.
  - Otherwise: hold.
- RUN:
  - `load`: restart as in IDLE, discarding the current count.
  - `stop`: `count`←0, go to IDLE, no `tc`.
  - `pause`: hold `count`.
  - Otherwise, `count`>1: decrement `count`.
  - Otherwise, `count`=1: `count`←0, `tc`←1, go to DONE.
- DONE:
  - `done` stays high until `ack`.
  - `ack` without `load`: go to IDLE, `count` stays 0.
  - `load`: implicit acknowledge, then restart as in IDLE in the same edge.
  - `stop` in DONE: go to IDLE.
  - `pause` in DONE: no effect.
- `ack` in IDLE or RUN is ignored.
- Arithmetic: unsigned, modulo 2^`WIDTH`. `count` never underflows, because 0 is never decremented.
- `busy` and `done` are registered decodes of state and are never high together.

## Timing
- Load at edge N: `count`=`load_val` and `busy`=1 after edge N.
- Unpaused run: `count` reaches 0 after edge N+`load_val`. At that point `tc`=1 for exactly one cycle, and `done`=1 and `busy`=0.
- Latency from load to `tc`: `load_val` cycles plus the number of paused cycles.
- Maximum count of 2^`WIDTH`−1 gives the maximum delay, e.g. 15 cycles at `WIDTH`=4.
- `ack` at edge M: `done`=0 after edge M.
- A load coinciding with the terminal edge restarts the count; `tc` is not pulsed.
- Asserting `rst` mid-operation clears all outputs immediately, without waiting for a clock edge.
- Deasserting `rst` is safe at any point; the block stays in IDLE until `load`.

## Configuration
- Macro `COUNTDOWN_AUTO_RELOAD_EN`.
- Defined:
  - In RUN, when `count`=1 and not paused, `count`←reload register and `tc`←1; the state stays RUN.
  - `count` never displays 0 in RUN, giving a period of exactly `load_val` cycles between `tc` pulses.
  - `done` is never asserted from RUN; RUN exits only via `stop`, `load`, or `rst`.
  - `load_val`=0 still goes to DONE.
- Undefined: one-shot behaviour exactly as described in Operation. The reload register may be optimised away.

## Test plan
- Reset, then load 3 at cycle 0: `count` reads 3,2,1,0. `tc` is high only in the cycle `count`=0, `done` holds until `ack`, and after `ack` the block is in IDLE with `count`=0.
- Load 5, then pause for 2 cycles after `count`=4: `tc` arrives 7 cycles after load; `count` holds 4 during the pause.
- Load 6, `stop` when `count`=3: `count`=0, `busy`=0, `done`=0, and `tc` never pulses. Separately, load 9 when `count`=2 in RUN: the count restarts at 9.
- Load 0: one cycle later `done`=1, `tc` pulsed once, `count`=0. `load` of 4 while in DONE clears `done` and starts RUN at 4.
- Assert `rst` asynchronously mid-RUN at `count`=2: all outputs are 0 before the next edge. `load` and `ack` asserted together during `rst` have no effect.
- With `COUNTDOWN_AUTO_RELOAD_EN` defined, load 4: `tc` pulses every 4 cycles for at least 3 periods, `count` cycles 4,3,2,1,4 and so on, and `done` stays 0; `stop` returns the block to IDLE.
